enc_pipe: RTL

//  Pipelined ECC encoder; counterpart of the DEC decoder. Takes info bits plus

---
 rtl/enc_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/enc_pipe.sv
// Two-stage extended-Hamming encoder with valid/ready handshakes. It produces 8-, 16- or 32-bit codewords.
// Optional ENC_ERR_INJECT_EN adds an err_mask port that is XORed into legal codewords.
module enc_pipe #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int AMBA_WORD          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic                          mode_err,
  output logic [AMBA_WORD-1:0]          enc_count
`ifdef ENC_ERR_INJECT_EN
  ,
  input  logic [MAX_CODEWORD_WIDTH-1:0] err_mask
`endif
);

  localparam int W = MAX_CODEWORD_WIDTH;

  // Info bit i is placed at the i-th column with at least two bits set.
  // The top parity bit makes the overall word parity even.
  function automatic logic [31:0] ham_enc(input logic [25:0] info, input int p);
    logic [31:0] cw;
    logic [5:0]  par;
    logic [4:0]  idx;
    logic [4:0]  col;
    logic [4:0]  p5;
    cw  = '0;
    par = '0;
    idx = '0;
    p5  = 5'(p);
    for (int c = 3; c < 32; c++) begin
      col = 5'(c);
      if (c < (1 << (p - 1)) && $countones(col) >= 2) begin
        for (int j = 0; j < 5; j++)
          if (j < p - 1 && col[j[2:0]]) par[j[2:0]] = par[j[2:0]] ^ info[idx];
        cw[idx + p5] = info[idx];
        idx = idx + 5'd1;
      end
    end
    for (int j = 0; j < 5; j++)
      if (j < p - 1) cw[j[4:0]] = par[j[2:0]];
    cw[p5 - 5'd1] = ^cw;
    return cw;
  endfunction

  logic [25:0] info_ext;
  genvar gi;
  generate
    for (gi = 0; gi < 26; gi++) begin : g_info
      if (gi < MAX_INFO_WIDTH) begin : g_bit
        assign info_ext[gi] = data_in[gi];
      end else begin : g_zero
        assign info_ext[gi] = 1'b0;
      end
    end
  endgenerate

  logic          s1_full_reg, s2_full_reg;
  logic [25:0]   s1_info_reg;
  logic [1:0]    s1_mode_reg;
  logic [W-1:0]  s2_cw_reg;
  logic          s2_err_reg;
  logic [AMBA_WORD-1:0] count_reg;
  logic [W-1:0]  mask_s1;
  logic [W-1:0]  mask_in;

`ifdef ENC_ERR_INJECT_EN
  logic [W-1:0]  s1_mask_reg;
  assign mask_in = err_mask;
  assign mask_s1 = s1_mask_reg;
`else
  assign mask_in = '0;
  assign mask_s1 = '0;
`endif

  logic s1_adv;
  assign s1_adv   = !s2_full_reg || out_ready;
  assign in_ready = !s1_full_reg || s1_adv;

  logic [31:0] enc_cw [3];
  generate
    for (gi = 0; gi < 3; gi++) begin : g_enc
      assign enc_cw[gi] = ham_enc(s1_info_reg, 4 + gi);
    end
  endgenerate

  logic          legal;
  logic [31:0]   sel_cw;
  logic [W-1:0]  cw_next;
  always_comb begin
    legal  = 1'b0;
    sel_cw = '0;
    case (s1_mode_reg)
      2'b00: begin legal = (W >= 8);  sel_cw = enc_cw[0]; end
      2'b01: begin legal = (W >= 16); sel_cw = enc_cw[1]; end
      2'b10: begin legal = (W >= 32); sel_cw = enc_cw[2]; end
      default: ;
    endcase
    // Illegal modes still move through the pipe, but they carry an all-zero word.
    cw_next = legal ? (sel_cw[W-1:0] ^ mask_s1) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_full_reg <= 1'b0;
      s1_info_reg <= '0;
      s1_mode_reg <= '0;
    end else if (in_ready) begin
      s1_full_reg <= in_valid;
      if (in_valid) begin
        s1_info_reg <= info_ext;
        s1_mode_reg <= work_mod;
      end
    end
  end

`ifdef ENC_ERR_INJECT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      s1_mask_reg <= '0;
    else if (in_ready && in_valid) s1_mask_reg <= mask_in;
  end
`else
  logic unused_mask;
  assign unused_mask = ^{mask_in, mask_s1};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_full_reg <= 1'b0;
      s2_cw_reg   <= '0;
      s2_err_reg  <= 1'b0;
    end else if (s1_adv) begin
      s2_full_reg <= s1_full_reg;
      if (s1_full_reg) begin
        s2_cw_reg  <= cw_next;
        s2_err_reg <= !legal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        count_reg <= '0;
    else if (s2_full_reg && out_ready) count_reg <= count_reg + 1'b1;
  end

  assign out_valid = s2_full_reg;
  assign data_out  = s2_cw_reg;
  assign mode_err  = s2_err_reg;
  assign enc_count = count_reg;

endmodule
